// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters.
module alu_arbiter #(
  parameter int A = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*(A+1)-1:0]   req_cmd,
  input  logic [15:0]          req_a,
  input  logic [15:0]          req_b,
  input  logic [1:0]           req_sc,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [7:0]           rsp_rslt,
  output logic                 rsp_sc,
  output logic                 rsp_pari,
  output logic [A:0]           alu_cmd,
  output logic [7:0]           alu_inA,
  output logic [7:0]           alu_inB,
  output logic                 alu_sc_i,
  input  logic [7:0]           alu_rslt,
  input  logic                 alu_sc_o,
  input  logic                 alu_pari,
  output logic [7:0]           ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, gnt;
  logic [A:0] cmd_q, cmd_d;
  logic [7:0] a_q, a_d, b_q, b_d, rslt_q, rslt_d, ops_q, ops_d;
  logic sc_q, sc_d, rsc_q, rsc_d, pari_q, pari_d, ex;
  // on a tie the requester that did not win last time goes next
  assign gnt = &req_valid ? ~last_q : req_valid[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sc_q    <= 1'b0;
      rslt_q  <= '0;
      rsc_q   <= 1'b0;
      pari_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sc_q    <= sc_d;
      rslt_q  <= rslt_d;
      rsc_q   <= rsc_d;
      pari_q  <= pari_d;
      ops_q   <= ops_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    sc_d    = sc_q;
    rslt_d  = rslt_q;
    rsc_d   = rsc_q;
    pari_d  = pari_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = EXEC;
        owner_d = gnt;
        last_d  = gnt;
        cmd_d   = gnt ? req_cmd[2*(A+1)-1 -: A+1] : req_cmd[A:0];
        a_d     = gnt ? req_a[15:8] : req_a[7:0];
        b_d     = gnt ? req_b[15:8] : req_b[7:0];
        sc_d    = gnt ? req_sc[1] : req_sc[0];
      end
      EXEC: begin
        state_d = RESP;
        rslt_d  = alu_rslt;
        rsc_d   = alu_sc_o;
        pari_d  = alu_pari;
      end
      RESP: if (owner_q ? rsp_ready[1] : rsp_ready[0]) begin
        state_d = IDLE;
        ops_d   = ops_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ex        = state_q == EXEC;
    req_ready = (state_q == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = state_q == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    alu_cmd   = ex ? cmd_q : '0;
    alu_inA   = ex ? a_q : 8'd0;
    alu_inB   = ex ? b_q : 8'd0;
    alu_sc_i  = ex ? sc_q : 1'b0;
  end
  assign rsp_rslt = rslt_q;
  assign rsp_sc   = rsc_q;
  assign rsp_pari = pari_q;
  assign ops_done = ops_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of alu_arbiter against a small reference ALU model.
module tb_alu_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_sc = '0, rsp_valid, rsp_ready = '0;
  logic [7:0] req_cmd = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [7:0] rsp_rslt, alu_inA, alu_inB, alu_rslt, ops_done;
  logic rsp_sc, rsp_pari, alu_sc_i, alu_sc_o, alu_pari;
  logic [3:0] alu_cmd;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.A(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .req_sc(req_sc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rslt(rsp_rslt),
    .rsp_sc(rsp_sc), .rsp_pari(rsp_pari), .alu_cmd(alu_cmd), .alu_inA(alu_inA),
    .alu_inB(alu_inB), .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt),
    .alu_sc_o(alu_sc_o), .alu_pari(alu_pari), .ops_done(ops_done)
  );
  // reference ALU: 0001 xor, 0011 add (carry out), 0100 B<<A, 0101 B>>A, others pass A with sc through
  always_comb begin
    logic [8:0] sum;
    sum = {1'b0, alu_inA} + {1'b0, alu_inB};
    alu_sc_o = alu_sc_i;
    case (alu_cmd)
      4'b0001: alu_rslt = alu_inA ^ alu_inB;
      4'b0011: begin alu_rslt = sum[7:0]; alu_sc_o = sum[8]; end
      4'b0100: alu_rslt = alu_inB << alu_inA[2:0];
      4'b0101: alu_rslt = alu_inB >> alu_inA[2:0];
      default: alu_rslt = alu_inA;
    endcase
    alu_pari = ^alu_rslt;
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask
  task automatic serve(input int i, input logic [3:0] c, input logic [7:0] a, b, input logic s,
                       output logic [1:0] v, output logic [7:0] r, output logic so, po);
    @(negedge clk);
    req_cmd[i*4 +: 4] = c; req_a[i*8 +: 8] = a; req_b[i*8 +: 8] = b; req_sc[i] = s;
    req_valid[i] = 1'b1;
    @(negedge clk);
    req_valid[i] = 1'b0;
    @(negedge clk);
    #1;
    v = rsp_valid; r = rsp_rslt; so = rsp_sc; po = rsp_pari;
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if ({req_ready, rsp_valid} !== 4'b0) $display("FAIL reset_hs got %b exp 0000", {req_ready, rsp_valid}); else pass_cnt++;
    total++; if ({alu_cmd, alu_inA, alu_inB, alu_sc_i} !== 21'd0) $display("FAIL reset_alu got %h exp 0", {alu_cmd, alu_inA, alu_inB, alu_sc_i}); else pass_cnt++;
    total++; if ({ops_done, rsp_rslt, rsp_sc, rsp_pari} !== 18'd0) $display("FAIL reset_regs got %h exp 0", {ops_done, rsp_rslt, rsp_sc, rsp_pari}); else pass_cnt++;
  endtask
  task automatic test_single_add();
    @(negedge clk);
    req_cmd[3:0] = 4'b0011; req_a[7:0] = 8'h7F; req_b[7:0] = 8'h01; req_sc[0] = 1'b1; req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL add_ready got %b exp 01", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    total++; if ({alu_cmd, alu_inA, alu_inB, alu_sc_i} !== {4'b0011, 8'h7F, 8'h01, 1'b1}) $display("FAIL add_exec_alu got %h %h %h %b exp 3 7f 01 1", alu_cmd, alu_inA, alu_inB, alu_sc_i); else pass_cnt++;
    total++; if (rsp_valid !== 2'b00) $display("FAIL add_exec_rsp got %b exp 00", rsp_valid); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 2'b01) $display("FAIL add_rsp_valid got %b exp 01", rsp_valid); else pass_cnt++;
    total++; if ({rsp_rslt, rsp_sc, rsp_pari} !== {8'h80, 1'b0, 1'b1}) $display("FAIL add_rsp got %h %b %b exp 80 0 1", rsp_rslt, rsp_sc, rsp_pari); else pass_cnt++;
    total++; if ({alu_cmd, alu_inA} !== 12'd0) $display("FAIL add_resp_alu got %h exp 0", {alu_cmd, alu_inA}); else pass_cnt++;
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    total++; if ({rsp_valid, ops_done} !== {2'b00, 8'd1}) $display("FAIL add_retire got %b %0d exp 00 1", rsp_valid, ops_done); else pass_cnt++;
  endtask
  task automatic test_shift();
    logic [1:0] v; logic [7:0] r; logic so, po;
    serve(0, 4'b0100, 8'h02, 8'h05, 1'b0, v, r, so, po);
    total++; if ({v, r} !== {2'b01, 8'h14}) $display("FAIL shl got %b %h exp 01 14", v, r); else pass_cnt++;
    serve(0, 4'b0101, 8'h01, 8'h05, 1'b0, v, r, so, po);
    total++; if ({v, r} !== {2'b01, 8'h02}) $display("FAIL shr got %b %h exp 01 02", v, r); else pass_cnt++;
    serve(1, 4'b1110, 8'hA5, 8'h00, 1'b1, v, r, so, po);
    total++; if ({v, r, so, po} !== {2'b10, 8'hA5, 1'b1, 1'b0}) $display("FAIL passthru got %b %h %b %b exp 10 a5 1 0", v, r, so, po); else pass_cnt++;
  endtask
  task automatic test_backpressure();
    logic [7:0] o0;
    o0 = ops_done;
    @(negedge clk);
    req_cmd[3:0] = 4'b0011; req_a[7:0] = 8'h10; req_b[7:0] = 8'h20; req_sc[0] = 1'b0; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b10; rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if ({rsp_valid, rsp_rslt, req_ready} !== {2'b01, 8'h30, 2'b00}) $display("FAIL bp_hold%0d got %b %h %b exp 01 30 00", k, rsp_valid, rsp_rslt, req_ready); else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    total++; if ({req_ready, ops_done} !== {2'b10, o0 + 8'd1}) $display("FAIL bp_release got %b %0d exp 10 %0d", req_ready, ops_done, o0 + 8'd1); else pass_cnt++;
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    total++; if ({alu_cmd, rsp_valid} !== 6'd0) $display("FAIL bp_drop got %h exp 0", {alu_cmd, rsp_valid}); else pass_cnt++;
  endtask
  task automatic test_wrap();
    logic [1:0] v; logic [7:0] r; logic so, po;
    int guard = 0;
    serve(1, 4'b0011, 8'hFF, 8'h02, 1'b0, v, r, so, po);
    total++; if ({v, r, so} !== {2'b10, 8'h01, 1'b1}) $display("FAIL wrap_add got %b %h %b exp 10 01 1", v, r, so); else pass_cnt++;
    while (ops_done != 8'hFF && guard < 300) begin
      serve(guard % 2, 4'b0011, 8'(guard), 8'h01, 1'b0, v, r, so, po);
      guard++;
    end
    total++; if (ops_done !== 8'hFF) $display("FAIL wrap_255 got %0d exp 255", ops_done); else pass_cnt++;
    serve(0, 4'b0001, 8'h0F, 8'hFF, 1'b0, v, r, so, po);
    total++; if ({ops_done, r} !== {8'd0, 8'hF0}) $display("FAIL wrap_zero got %0d %h exp 0 f0", ops_done, r); else pass_cnt++;
  endtask
  task automatic test_tie();
    do_reset();
    @(negedge clk);
    req_cmd = {4'b0011, 4'b0001}; req_a = {8'h01, 8'hF0}; req_b = {8'h01, 8'h3C}; req_sc = 2'b00;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL tie_first got %b exp 01", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    total++; if ({alu_inA, req_ready} !== {8'hF0, 2'b00}) $display("FAIL tie_exec got %h %b exp f0 00", alu_inA, req_ready); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if ({rsp_valid, rsp_rslt} !== {2'b01, 8'hCC}) $display("FAIL tie_rsp0 got %b %h exp 01 cc", rsp_valid, rsp_rslt); else pass_cnt++;
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    total++; if (req_ready !== 2'b10) $display("FAIL tie_second got %b exp 10", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    total++; if ({rsp_valid, rsp_rslt} !== {2'b10, 8'h02}) $display("FAIL tie_rsp1 got %b %h exp 10 02", rsp_valid, rsp_rslt); else pass_cnt++;
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL tie_next got %b exp 01", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    total++; if ({alu_cmd, rsp_valid, ops_done} !== {4'd0, 2'b00, 8'd2}) $display("FAIL tie_withdraw got %h %b %0d exp 0 00 2", alu_cmd, rsp_valid, ops_done); else pass_cnt++;
  endtask
  task automatic test_reset_mid_op();
    do_reset();
    @(negedge clk);
    req_cmd[3:0] = 4'b0011; req_a[7:0] = 8'h05; req_b[7:0] = 8'h06; req_sc[0] = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    total++; if (alu_inA !== 8'h05) $display("FAIL mid_exec got %h exp 05", alu_inA); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({rsp_valid, req_ready, ops_done} !== 12'd0) $display("FAIL mid_state got %b %b %0d exp 00 00 0", rsp_valid, req_ready, ops_done); else pass_cnt++;
    total++; if ({alu_cmd, alu_inA, alu_inB, alu_sc_i} !== 21'd0) $display("FAIL mid_alu got %h exp 0", {alu_cmd, alu_inA, alu_inB, alu_sc_i}); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if ({rsp_valid, ops_done, rsp_rslt} !== 18'd0) $display("FAIL mid_after got %b %0d %h exp 00 0 00", rsp_valid, ops_done, rsp_rslt); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_single_add();
    test_shift();
    test_backpressure();
    test_wrap();
    test_tie();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
